cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
//  Memory-side end of the CPU memory bus: accepts line requests issued by the
//  cache miss/write-back path and answers them on the response bus.
//  Line-wide backing store with fixed, parameterised access latency.
//  One request outstanding at a time.
//  Used as main-memory model in core/system sims; target for synthesis as on-chip RAM.
// PARAMETERS
//  ADDR_WIDTH   `PHYSICAL_ADDR_WIDTH  physical byte-address width
//  LINE_WIDTH   128                   cache line width in bits (power of 2, >=8)
//  DEPTH_LINES  256                   number of lines stored (power of 2)
//  LATENCY      5                     edges from request accept to response (>=1)
// PORTS
//  clock      in   1           system clock, rising edge
//  reset      in   1           asynchronous, active-high
//  req_valid  in   1           request present
//  req_ready  out  1           responder can accept a request this cycle
//  req_write  in   1           1 = line write, 0 = line read
//  req_addr   in   ADDR_WIDTH  byte address of line
//  req_data   in   LINE_WIDTH  write data (ignored on read)
//  rsp_valid  out  1           response present (one-cycle pulse, no backpressure)
//  rsp_write  out  1           echo of req_write for this response
//  rsp_addr   out  ADDR_WIDTH  echo of req_addr, offset bits forced to 0
//  rsp_data   out  LINE_WIDTH  read: stored line; write: line written
// BEHAVIOUR
//  - Address map: OFF=$clog2(LINE_WIDTH/8); IDX=$clog2(DEPTH_LINES);
//    line index = req_addr[OFF +: IDX]; bits above OFF+IDX ignored (aliasing wraps).
//  - Reset (async): state=IDLE, req_ready=1 once reset deasserted (0 while reset high),
//    rsp_valid=0, rsp_write=0, rsp_addr=0, rsp_data=0, counter=0.
//    Array contents NOT reset; reads of unwritten lines return X in sim.
//  - FSM: IDLE -> BUSY -> RESPOND -> IDLE.
//    IDLE:    req_ready=1. Accept on edge with req_valid&req_ready: latch write/addr/data,
//             counter<=LATENCY-1, go BUSY. req_valid with ready low is ignored (not queued).
//    BUSY:    req_ready=0. counter!=0: decrement. counter==0: at this edge perform
//             access (write updates array / read captures line), load rsp_* regs,
//             rsp_valid<=1, go RESPOND.
//    RESPOND: req_ready=0, rsp_valid=1 for exactly this cycle; next edge rsp_valid<=0, go IDLE.
//  - Timing: accept at edge E0 -> rsp_valid high between E0+LATENCY and
//    E0+LATENCY+1; req_ready high again after E0+LATENCY+1; earliest next accept
//    at E0+LATENCY+2. Throughput 1 request per LATENCY+2 cycles.
//  - rsp_* regs hold their last value after rsp_valid drops (until next response).
//  - Write is committed only at BUSY->RESPOND edge; read-after-write to same line
//    returns new data. Read of line returns full LINE_WIDTH, no byte masking.
//  - Reset asserted in BUSY: request aborted, array unchanged, no response issued.
//    Reset in RESPOND: rsp_valid cleared immediately (async), write already committed.
//  - Counter width $clog2(LATENCY+1); no wrap possible since load <= LATENCY-1.
// TESTING
//  1. Reset, LATENCY=5: req_ready=1, rsp_valid=0; write addr 0x00040 data 0xDEAD..BEEF
//     accepted E0 -> rsp_valid pulse 1 cycle at E5, rsp_write=1, rsp_addr=0x00040.
//  2. Read addr 0x0004C after test 1 -> rsp at E0+5, rsp_addr=0x00040,
//     rsp_data=0xDEAD..BEEF (offset bits ignored).
//  3. req_valid held high continuously with alternating addrs -> accepts spaced
//     exactly 7 edges apart, req_ready=0 throughout BUSY/RESPOND, no lost/dup rsp.
//  4. Aliasing: write addr (DEPTH_LINES*LINE_WIDTH/8)+0x10 data 0x1, read 0x10 -> 0x1.
//  5. Write 0x2 to line 3, assert reset 2 edges after accept: no rsp_valid, all outputs 0;
//     after release read line 3 -> prior contents (not 0x2).
//  6. LATENCY=1 build: accept at E0 -> rsp_valid high E1..E2, next accept at E3.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU line bus: a line-wide backing store that
// answers one outstanding read or write request after a fixed latency.
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif

module cpu_mem_responder #(
  parameter int ADDR_WIDTH  = `PHYSICAL_ADDR_WIDTH,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [LINE_WIDTH-1:0] rsp_data
);

  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam int IDX   = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESPOND
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic [IDX-1:0]        idx_q;
  logic                  access;

  logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];

  // Upper address bits above the index are ignored, so the line space aliases.
  assign idx_q     = addr_q[OFF +: IDX];
  assign access    = (state == S_BUSY) && (count == '0);
  assign req_ready = (state == S_IDLE) && !reset;

  // NOTE: the array is deliberately left out of reset so it maps onto a plain RAM;
  // an aborted request never reaches this write because reset forces the FSM to IDLE.
  always_ff @(posedge clock) begin
    if (access && wr_q) begin
      mem[idx_q] <= data_q;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q   <= req_write;
            addr_q <= req_addr;
            data_q <= req_data;
            count  <= CNT_LOAD;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            // A write echoes the line being committed on this same edge.
            rsp_valid <= 1'b1;
            rsp_write <= wr_q;
            rsp_addr  <= addr_q & OFF_MASK;
            rsp_data  <= wr_q ? data_q : mem[idx_q];
            state     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: a LATENCY=5 instance for the main
// scenarios and a LATENCY=1 instance for minimum-latency timing.
module tb_cpu_mem_responder;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int DL = 256;
  localparam logic [LW-1:0] DATA_A = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [LW-1:0] req_data  = '0;
  logic          req_ready, rsp_valid, rsp_write;
  logic [AW-1:0] rsp_addr;
  logic [LW-1:0] rsp_data;

  logic          f_req_valid = 1'b0;
  logic          f_req_write = 1'b0;
  logic [AW-1:0] f_req_addr  = '0;
  logic [LW-1:0] f_req_data  = '0;
  logic          f_req_ready, f_rsp_valid, f_rsp_write;
  logic [AW-1:0] f_rsp_addr;
  logic [LW-1:0] f_rsp_data;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  cpu_mem_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH_LINES(DL), .LATENCY(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_addr(rsp_addr), .rsp_data(rsp_data)
  );

  cpu_mem_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH_LINES(DL), .LATENCY(1)) dut_fast (
    .clock(clock), .reset(reset),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
    .req_addr(f_req_addr), .req_data(f_req_data),
    .rsp_valid(f_rsp_valid), .rsp_write(f_rsp_write), .rsp_addr(f_rsp_addr), .rsp_data(f_rsp_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // Drives a request from a falling edge; acc is the rising edge that accepts it.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d,
                      output int acc, output bit ok);
    ok  = 1'b0;
    acc = -1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        acc = cyc + 1;
        ok  = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Returns at the falling edge where rsp_valid is first seen high.
  task automatic wait_rsp(output int rc, output bit ok);
    ok = 1'b0;
    rc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        rc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_addr !== '0) begin miscompares++; $display("FAIL reset_rsp_addr: got %h want 0", rsp_addr); end
    vectors++; if (rsp_data !== '0) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b want 1", req_ready); end
    @(negedge clock);
  endtask

  task automatic test_write();
    int acc, rc;
    bit ok;
    send(1'b1, 32'h0000_0040, DATA_A, acc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr_accept: got timeout want accept"); end
    wait_rsp(rc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr_rsp: got timeout want rsp_valid"); end
    vectors++; if (rc - acc !== 5) begin miscompares++; $display("FAIL wr_latency: got %0d want 5", rc - acc); end
    vectors++; if (rsp_write !== 1'b1) begin miscompares++; $display("FAIL wr_rsp_write: got %b want 1", rsp_write); end
    vectors++; if (rsp_addr !== 32'h40) begin miscompares++; $display("FAIL wr_rsp_addr: got %h want 40", rsp_addr); end
    vectors++; if (rsp_data !== DATA_A) begin miscompares++; $display("FAIL wr_rsp_data: got %h want %h", rsp_data, DATA_A); end
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL wr_ready_respond: got %b want 0", req_ready); end
    @(negedge clock);
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_pulse_width: got %b want 0", rsp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready_idle: got %b want 1", req_ready); end
    vectors++; if (rsp_data !== DATA_A) begin miscompares++; $display("FAIL wr_rsp_hold: got %h want %h", rsp_data, DATA_A); end
  endtask

  task automatic test_read_offset();
    int acc, rc;
    bit ok;
    send(1'b0, 32'h0000_004C, '0, acc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rd_accept: got timeout want accept"); end
    wait_rsp(rc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rd_rsp: got timeout want rsp_valid"); end
    vectors++; if (rc - acc !== 5) begin miscompares++; $display("FAIL rd_latency: got %0d want 5", rc - acc); end
    vectors++; if (rsp_write !== 1'b0) begin miscompares++; $display("FAIL rd_rsp_write: got %b want 0", rsp_write); end
    vectors++; if (rsp_addr !== 32'h40) begin miscompares++; $display("FAIL rd_rsp_addr: got %h want 40", rsp_addr); end
    vectors++; if (rsp_data !== DATA_A) begin miscompares++; $display("FAIL rd_rsp_data: got %h want %h", rsp_data, DATA_A); end
    @(negedge clock);
  endtask

  task automatic test_aliasing();
    int acc, rc;
    bit ok;
    send(1'b1, 32'(DL * LW / 8 + 'h10), 128'h1, acc, ok);
    wait_rsp(rc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL alias_wr_rsp: got timeout want rsp_valid"); end
    vectors++; if (rsp_addr !== 32'h1010) begin miscompares++; $display("FAIL alias_wr_addr: got %h want 1010", rsp_addr); end
    @(negedge clock);
    send(1'b0, 32'h10, '0, acc, ok);
    wait_rsp(rc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL alias_rd_rsp: got timeout want rsp_valid"); end
    vectors++; if (rsp_data !== 128'h1) begin miscompares++; $display("FAIL alias_rd_data: got %h want 1", rsp_data); end
    vectors++; if (rsp_addr !== 32'h10) begin miscompares++; $display("FAIL alias_rd_addr: got %h want 10", rsp_addr); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int accs[$];
    logic [AW-1:0] raddrs[$];
    logic [LW-1:0] rdatas[$];
    int  ready_hi = 0;
    bit  toggle   = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h40;
    for (int i = 0; i < 21; i++) begin
      if (rsp_valid) begin
        raddrs.push_back(rsp_addr);
        rdatas.push_back(rsp_data);
      end
      if (toggle) begin
        req_addr = (req_addr == 32'h40) ? 32'h10 : 32'h40;
        toggle   = 1'b0;
      end
      if (req_ready) begin
        accs.push_back(cyc + 1);
        ready_hi++;
        toggle = 1'b1;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    vectors++; if (accs.size() !== 3) begin miscompares++; $display("FAIL b2b_accepts: got %0d want 3", accs.size()); end
    vectors++; if (ready_hi !== 3) begin miscompares++; $display("FAIL b2b_ready_cycles: got %0d want 3", ready_hi); end
    vectors++; if (raddrs.size() !== 3) begin miscompares++; $display("FAIL b2b_responses: got %0d want 3", raddrs.size()); end
    if (accs.size() >= 3) begin
      vectors++; if (accs[1] - accs[0] !== 7) begin miscompares++; $display("FAIL b2b_spacing0: got %0d want 7", accs[1] - accs[0]); end
      vectors++; if (accs[2] - accs[1] !== 7) begin miscompares++; $display("FAIL b2b_spacing1: got %0d want 7", accs[2] - accs[1]); end
    end
    if (raddrs.size() >= 3) begin
      vectors++; if (raddrs[0] !== 32'h40 || raddrs[1] !== 32'h10 || raddrs[2] !== 32'h40) begin
        miscompares++; $display("FAIL b2b_addr_order: got %h %h %h want 40 10 40", raddrs[0], raddrs[1], raddrs[2]);
      end
      vectors++; if (rdatas[1] !== 128'h1) begin miscompares++; $display("FAIL b2b_data1: got %h want 1", rdatas[1]); end
    end
    @(negedge clock);
  endtask

  task automatic test_reset_abort();
    int acc, rc, seen;
    bit ok;
    send(1'b1, 32'h30, 128'h33, acc, ok);
    wait_rsp(rc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL abort_prefill: got timeout want rsp_valid"); end
    @(negedge clock);
    send(1'b1, 32'h30, 128'h2, acc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL abort_accept: got timeout want accept"); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++; if ({req_ready, rsp_valid, rsp_write} !== 3'b000) begin
      miscompares++; $display("FAIL abort_ctrl_outputs: got %b want 000", {req_ready, rsp_valid, rsp_write});
    end
    vectors++; if (rsp_addr !== '0 || rsp_data !== '0) begin
      miscompares++; $display("FAIL abort_data_outputs: got %h/%h want 0/0", rsp_addr, rsp_data);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_rsp: got %0d want 0", seen); end
    send(1'b0, 32'h30, '0, acc, ok);
    wait_rsp(rc, ok);
    vectors++; if (rsp_data !== 128'h33) begin miscompares++; $display("FAIL abort_array: got %h want 33", rsp_data); end
    @(negedge clock);
  endtask

  task automatic test_min_latency();
    int accs[$];
    int rsps[$];
    f_req_valid = 1'b1;
    f_req_write = 1'b1;
    f_req_addr  = 32'h20;
    f_req_data  = 128'h5;
    for (int i = 0; i < 7; i++) begin
      if (f_rsp_valid) rsps.push_back(cyc);
      if (f_req_ready) accs.push_back(cyc + 1);
      @(negedge clock);
    end
    f_req_valid = 1'b0;
    repeat (4) @(negedge clock);
    vectors++; if (accs.size() !== 3) begin miscompares++; $display("FAIL lat1_accepts: got %0d want 3", accs.size()); end
    vectors++; if (rsps.size() !== 2) begin miscompares++; $display("FAIL lat1_responses: got %0d want 2", rsps.size()); end
    if (accs.size() >= 2 && rsps.size() >= 1) begin
      vectors++; if (rsps[0] - accs[0] !== 1) begin miscompares++; $display("FAIL lat1_latency: got %0d want 1", rsps[0] - accs[0]); end
      vectors++; if (accs[1] - accs[0] !== 3) begin miscompares++; $display("FAIL lat1_spacing: got %0d want 3", accs[1] - accs[0]); end
    end
    vectors++; if (f_rsp_data !== 128'h5) begin miscompares++; $display("FAIL lat1_rsp_data: got %h want 5", f_rsp_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_offset();
    test_aliasing();
    test_back_to_back();
    test_reset_abort();
    test_min_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
